// File: rtl/text_line_composer.sv
// Status-line writer: snapshots vend state and money values, converts the amount
// to BCD, writes a 16-char message into the back buffer, swaps on frame start.
module text_line_composer #(
    parameter int          LINE_LEN   = 16,
    parameter logic [7:0]  SPACE_CHAR = 8'h20,
    parameter logic [7:0]  CENT_CHAR  = 8'h43
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] state,
    input  logic [7:0] total,
    input  logic [7:0] change,
    input  logic [1:0] selected_item,
    input  logic       update_req,
    input  logic       frame_start,
    input  logic [3:0] rd_col,
    output logic [7:0] rd_char,
    output logic       busy,
    output logic       swap_done
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_READY   = 2'd3;

    // Fixed text of each message; numeric and item fields are overlaid while writing.
    localparam logic [8*16-1:0] MSG_IDLE    = "INSERT COIN     ";
    localparam logic [8*16-1:0] MSG_COLLECT = "TOTAL:          ";
    localparam logic [8*16-1:0] MSG_CHANGE  = "CHANGE:         ";
    localparam logic [8*16-1:0] MSG_VEND    = "VEND ITEM       ";

    logic [1:0]  fsm_q, fsm_d;
    logic        snap_valid_q;
    logic [1:0]  snap_state_q, snap_item_q;
    logic [7:0]  snap_total_q, snap_change_q;
    logic [7:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d, bcd_adj;
    logic [2:0]  step_q, step_d;
    logic [3:0]  col_q, col_d;
    logic        sel_q, front_valid_q, swap_done_q;
    logic        trigger;
    logic [7:0]  operand;
    logic [8*16-1:0] tmpl;
    logic [7:0]  wr_char, hund_char, tens_char, ones_char;

    logic [7:0] line0_q [LINE_LEN];
    logic [7:0] line1_q [LINE_LEN];

    assign trigger = (fsm_q == ST_IDLE) &&
                     (update_req || !snap_valid_q ||
                      ({state, total, change, selected_item} !=
                       {snap_state_q, snap_total_q, snap_change_q, snap_item_q}));

    always_comb begin
        operand = 8'd0;
        case (state)
            2'b01:   operand = total;
            2'b10:   operand = change;
            default: operand = 8'd0;
        endcase
    end

    // Double dabble: each BCD digit >= 5 gets +3 before the shift.
    for (genvar gi = 0; gi < 3; gi++) begin : g_add3
        assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                    bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end

    always_comb begin
        fsm_d  = fsm_q;
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        step_d = step_q;
        col_d  = col_q;
        case (fsm_q)
            ST_IDLE: begin
                if (trigger) begin
                    fsm_d  = ST_CONVERT;
                    bin_d  = operand;
                    bcd_d  = 12'd0;
                    step_d = 3'd0;
                end
            end
            ST_CONVERT: begin
                bcd_d  = {bcd_adj[10:0], bin_q[7]};
                bin_d  = {bin_q[6:0], 1'b0};
                step_d = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    fsm_d = ST_WRITE;
                    col_d = 4'd0;
                end
            end
            ST_WRITE: begin
                col_d = col_q + 4'd1;
                if (col_q == 4'd15) begin
                    fsm_d = ST_READY;
                end
            end
            default: begin
                if (frame_start) begin
                    fsm_d = ST_IDLE;
                end
            end
        endcase
    end

    assign hund_char = (bcd_q[11:8] == 4'd0) ? SPACE_CHAR : {4'h3, bcd_q[11:8]};
    assign tens_char = (bcd_q[11:4] == 8'd0) ? SPACE_CHAR : {4'h3, bcd_q[7:4]};
    assign ones_char = {4'h3, bcd_q[3:0]};

    always_comb begin
        case (snap_state_q)
            2'b00:   tmpl = MSG_IDLE;
            2'b01:   tmpl = MSG_COLLECT;
            2'b10:   tmpl = MSG_CHANGE;
            default: tmpl = MSG_VEND;
        endcase
        wr_char = tmpl[{4'd15 - col_q, 3'b000} +: 8];
        case (snap_state_q)
            2'b01: begin
                case (col_q)
                    4'd7:    wr_char = hund_char;
                    4'd8:    wr_char = tens_char;
                    4'd9:    wr_char = ones_char;
                    4'd10:   wr_char = CENT_CHAR;
                    default: ;
                endcase
            end
            2'b10: begin
                case (col_q)
                    4'd8:    wr_char = hund_char;
                    4'd9:    wr_char = tens_char;
                    4'd10:   wr_char = ones_char;
                    4'd11:   wr_char = CENT_CHAR;
                    default: ;
                endcase
            end
            2'b11: begin
                if (col_q == 4'd10) begin
                    wr_char = 8'h31 + {6'd0, snap_item_q};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q         <= ST_IDLE;
            bin_q         <= 8'd0;
            bcd_q         <= 12'd0;
            step_q        <= 3'd0;
            col_q         <= 4'd0;
            snap_valid_q  <= 1'b0;
            snap_state_q  <= 2'd0;
            snap_total_q  <= 8'd0;
            snap_change_q <= 8'd0;
            snap_item_q   <= 2'd0;
            sel_q         <= 1'b0;
            front_valid_q <= 1'b0;
            swap_done_q   <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            step_q      <= step_d;
            col_q       <= col_d;
            swap_done_q <= (fsm_q == ST_READY) && frame_start;
            if (trigger) begin
                snap_valid_q  <= 1'b1;
                snap_state_q  <= state;
                snap_total_q  <= total;
                snap_change_q <= change;
                snap_item_q   <= selected_item;
            end
            if ((fsm_q == ST_READY) && frame_start) begin
                sel_q         <= ~sel_q;
                front_valid_q <= 1'b1;
            end
        end
    end

    // sel_q=0: line0 is front, line1 is back; writes never touch the front.
    always_ff @(posedge clk) begin
        if (fsm_q == ST_WRITE) begin
            if (sel_q) begin
                line0_q[col_q] <= wr_char;
            end else begin
                line1_q[col_q] <= wr_char;
            end
        end
    end

    assign rd_char   = !front_valid_q ? SPACE_CHAR :
                       (sel_q ? line1_q[rd_col] : line0_q[rd_col]);
    assign busy      = (fsm_q != ST_IDLE);
    assign swap_done = swap_done_q;

endmodule

// File: tb/tb_text_line_composer.sv
// Scoreboard bench: stimulus pushes expected lines, a monitor reads the front
// buffer after every swap and compares against a string-level message model.
`timescale 1ns/100ps
module tb_text_line_composer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state = 2'd0;
    logic [7:0] total = 8'd0;
    logic [7:0] change = 8'd0;
    logic [1:0] selected_item = 2'd0;
    logic       update_req = 1'b0;
    logic       frame_start = 1'b0;
    logic [3:0] rd_col = 4'd0;
    logic [7:0] rd_char;
    logic       busy;
    logic       swap_done;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];
    logic [127:0] blank_line;

    logic [1:0] snap_st;
    logic [7:0] snap_tot, snap_chg;
    logic [1:0] snap_itm;

    text_line_composer dut (
        .clk(clk), .rst_n(rst_n), .state(state), .total(total), .change(change),
        .selected_item(selected_item), .update_req(update_req),
        .frame_start(frame_start), .rd_col(rd_col), .rd_char(rd_char),
        .busy(busy), .swap_done(swap_done)
    );

    always #5 clk = ~clk;

    function automatic string num3(input int v);
        if (v >= 100) return $sformatf("%0d", v);
        else if (v >= 10) return {" ", $sformatf("%0d", v)};
        else return {"  ", $sformatf("%0d", v)};
    endfunction

    function automatic logic [127:0] model_line(input logic [1:0] st, input logic [7:0] tot,
                                                input logic [7:0] chg, input logic [1:0] itm);
        string s;
        logic [127:0] l;
        case (st)
            2'b00:   s = "INSERT COIN";
            2'b01:   s = {"TOTAL: ", num3(int'(tot)), "C"};
            2'b10:   s = {"CHANGE: ", num3(int'(chg)), "C"};
            default: s = {"VEND ITEM ", $sformatf("%c", 8'h31 + {6'd0, itm})};
        endcase
        while (s.len() < 16) s = {s, " "};
        for (int i = 0; i < 16; i++) l[8*(15-i) +: 8] = s[i];
        return l;
    endfunction

    task automatic chk1(input string name, input logic got, input logic expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, got, expv, $time);
        end
    endtask

    task automatic chk_line(input string name, input logic [127:0] got, input logic [127:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\" at %0t", name, got, expv, $time);
        end else begin
            $display("line ok: \"%s\" at %0t", got, $time);
        end
    endtask

    task automatic scan(output logic [127:0] line);
        for (int c = 0; c < 16; c++) begin
            rd_col = 4'(c);
            #0.1;
            line[8*(15-c) +: 8] = rd_char;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a clock edge with the DUT idle; returns just after the swap edge.
    task automatic compose(input logic [1:0] st, input logic [7:0] tot, input logic [7:0] chg,
                           input logic [1:0] itm, input bit upd, input bit mid,
                           input logic [7:0] mid_tot);
        int d;
        state = st; total = tot; change = chg; selected_item = itm;
        update_req = upd;
        frame_start = 1'b1;
        exp_q.push_back(model_line(st, tot, chg, itm));
        d = $urandom_range(0, 3);
        for (int k = 1; k <= 25; k++) begin
            cyc(1);
            update_req = 1'b0;
            chk1("busy_during_compose", busy, 1'b1);
            chk1("no_early_swap", swap_done, 1'b0);
            if (mid && k == 12) total = mid_tot;
            if (k == 25) frame_start = (d == 0);
        end
        for (int j = 1; j <= d; j++) begin
            cyc(1);
            chk1("busy_in_ready", busy, 1'b1);
            chk1("no_swap_without_frame", swap_done, 1'b0);
            frame_start = (j == d);
        end
        cyc(1);
        chk1("swap_pulse", swap_done, 1'b1);
        frame_start = 1'b0;
        snap_st = st; snap_tot = tot; snap_chg = chg; snap_itm = itm;
    endtask

    initial begin : monitor
        logic [127:0] got, e;
        forever begin
            @(negedge clk);
            if (swap_done === 1'b1) begin
                chk1("swap_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    scan(got);
                    chk_line("front_line", got, e);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [127:0] got;
        logic [1:0] st, itm;
        logic [7:0] tot, chg;
        bit upd;
        blank_line = {16{8'h20}};

        cyc(3);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_swap", swap_done, 1'b0);
        scan(got);
        chk_line("reset_blank", got, blank_line);
        rst_n = 1'b1;
        scan(got);
        chk_line("blank_before_first_swap", got, blank_line);
        compose(2'b00, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, 8'd0);

        compose(2'b01, 8'd75, 8'd0, 2'd0, 1'b0, 1'b0, 8'd0);
        compose(2'b10, 8'd75, 8'd0, 2'd0, 1'b0, 1'b0, 8'd0);
        compose(2'b10, 8'd75, 8'd255, 2'd0, 1'b0, 1'b0, 8'd0);
        compose(2'b11, 8'd75, 8'd255, 2'd3, 1'b0, 1'b0, 8'd0);
        cyc(1);
        chk1("idle_when_unchanged", busy, 1'b0);
        chk1("swap_is_one_cycle", swap_done, 1'b0);

        // Change during WRITE is not latched; the idle compare recomposes right after the swap.
        compose(2'b01, 8'd25, 8'd0, 2'd0, 1'b0, 1'b1, 8'd50);
        compose(2'b01, 8'd50, 8'd0, 2'd0, 1'b0, 1'b0, 8'd0);
        compose(2'b01, 8'd50, 8'd0, 2'd0, 1'b1, 1'b0, 8'd0);

        // Reset in the middle of WRITE blanks the display and recomposes after release.
        state = 2'b01; total = 8'd99;
        cyc(15);
        rst_n = 1'b0;
        #1;
        chk1("reset_mid_busy", busy, 1'b0);
        scan(got);
        chk_line("reset_mid_blank", got, blank_line);
        cyc(2);
        chk1("reset_mid_swap", swap_done, 1'b0);
        rst_n = 1'b1;
        compose(2'b01, 8'd99, 8'd0, 2'd0, 1'b0, 1'b0, 8'd0);

        for (int n = 0; n < 20; n++) begin
            st  = 2'($urandom_range(0, 3));
            tot = 8'($urandom_range(0, 255));
            chg = 8'($urandom_range(0, 255));
            itm = 2'($urandom_range(0, 3));
            if (n % 5 == 0) tot = (n % 10 == 0) ? 8'd9 : 8'd100;
            upd = ($urandom_range(0, 3) == 0);
            if ({st, tot, chg, itm} == {snap_st, snap_tot, snap_chg, snap_itm}) upd = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                cyc($urandom_range(1, 3));
                chk1("idle_between_composes", busy, 1'b0);
            end
            compose(st, tot, chg, itm, upd, 1'b0, 8'd0);
        end

        cyc(5);
        chk1("scoreboard_drained", exp_q.size() == 0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
